// File: rtl/cambricon_d_pkg.sv
// Shared types and default sizing for the Cambricon-D delta encoder.
package cambricon_d_pkg;

    localparam int DEF_FRAME_SIZE  = 1024;
    localparam int DEF_FULL_WIDTH  = 16;
    localparam int DEF_DELTA_WIDTH = 3;
    localparam int DEF_SHIFT       = 4;

    localparam int DELTA_MIN = -(2 ** (DEF_DELTA_WIDTH - 1));
    localparam int DELTA_MAX = (2 ** (DEF_DELTA_WIDTH - 1)) - 1;

    typedef enum logic [0:0] {
        INIT = 1'b0,
        RUN  = 1'b1
    } enc_state_e;

    typedef struct packed {
        logic [DEF_DELTA_WIDTH-1:0]         delta;
        logic                               sign;
        logic                               outlier;
        logic [DEF_FULL_WIDTH-1:0]          value;
        logic [$clog2(DEF_FRAME_SIZE)-1:0]  index;
        logic                               last;
    } delta_beat_t;

endpackage

// File: rtl/delta_ref_ram.sv
// Per-element reference store: one write port, one registered read port, no reset.
module delta_ref_ram #(
    parameter  int DEPTH = 1024,
    parameter  int WIDTH = 16,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Read data holds while rd_en is low so a stalled stage 1 keeps its reference.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/cambricon_d_delta_encoder.sv
// Delta encoder: subtracts the previous-timestep reference per element and
// quantizes the difference, escaping unrepresentable deltas as outliers.
module cambricon_d_delta_encoder
    import cambricon_d_pkg::*;
#(
    parameter  int FRAME_SIZE  = DEF_FRAME_SIZE,
    parameter  int FULL_WIDTH  = DEF_FULL_WIDTH,
    parameter  int DELTA_WIDTH = DEF_DELTA_WIDTH,
    parameter  int SHIFT       = DEF_SHIFT,
    localparam int IW          = $clog2(FRAME_SIZE)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [FULL_WIDTH-1:0]  in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DELTA_WIDTH-1:0] out_delta,
    output logic                   out_sign,
    output logic                   out_outlier,
    output logic [FULL_WIDTH-1:0]  out_value,
    output logic [IW-1:0]          out_index,
    output logic                   out_last
);

    localparam int            DELTA_LO = -(2 ** (DELTA_WIDTH - 1));
    localparam int            DELTA_HI = (2 ** (DELTA_WIDTH - 1)) - 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(FRAME_SIZE - 1);

    enc_state_e state;
    logic [IW-1:0] init_addr;
    logic [IW-1:0] idx;

    logic                         s1_valid;
    logic signed [FULL_WIDTH-1:0] s1_x;
    logic [IW-1:0]                s1_idx;

    logic [FULL_WIDTH-1:0]        rd_data;
    logic signed [FULL_WIDTH-1:0] ref_q;
    logic signed [FULL_WIDTH:0]   diff;
    logic signed [FULL_WIDTH:0]   q;
    logic signed [FULL_WIDTH+1:0] recon;
    logic [FULL_WIDTH-1:0]        ref_sat;
    logic [FULL_WIDTH-1:0]        ref_new;
    logic                         inlier;

    logic advance;
    logic accept;
    logic s2_move;

    logic                  ram_we;
    logic [IW-1:0]         ram_waddr;
    logic [FULL_WIDTH-1:0] ram_wdata;

    assign advance  = ~out_valid | out_ready;
    assign in_ready = (state == RUN) & (~s1_valid | advance);
    assign accept   = in_valid & in_ready;
    assign s2_move  = s1_valid & advance;

    // Stage 2 arithmetic on the stage-1 element and its reference
    assign ref_q  = $signed(rd_data);
    assign diff   = {s1_x[FULL_WIDTH-1], s1_x} - {ref_q[FULL_WIDTH-1], ref_q};
    assign q      = diff >>> SHIFT;
    assign inlier = (q >= (FULL_WIDTH+1)'(DELTA_LO)) && (q <= (FULL_WIDTH+1)'(DELTA_HI));
    assign recon  = (FULL_WIDTH+2)'(ref_q) + ((FULL_WIDTH+2)'(q) <<< SHIFT);

    // The stored reference tracks what the decoder reconstructs, clamped to range.
    always_comb begin
        ref_sat = recon[FULL_WIDTH-1:0];
        if ((recon[FULL_WIDTH+1:FULL_WIDTH-1] != 3'b000) &&
            (recon[FULL_WIDTH+1:FULL_WIDTH-1] != 3'b111)) begin
            ref_sat = recon[FULL_WIDTH+1] ? {1'b1, {(FULL_WIDTH-1){1'b0}}}
                                          : {1'b0, {(FULL_WIDTH-1){1'b1}}};
        end
    end

    assign ref_new = inlier ? ref_sat : s1_x;

    assign ram_we    = (state == INIT) | s2_move;
    assign ram_waddr = (state == INIT) ? init_addr : s1_idx;
    assign ram_wdata = (state == INIT) ? '0 : ref_new;

    delta_ref_ram #(
        .DEPTH (FRAME_SIZE),
        .WIDTH (FULL_WIDTH)
    ) u_ref_ram (
        .clk     (clk),
        .wr_en   (ram_we),
        .wr_addr (ram_waddr),
        .wr_data (ram_wdata),
        .rd_en   (accept),
        .rd_addr (idx),
        .rd_data (rd_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= INIT;
            init_addr   <= '0;
            idx         <= '0;
            s1_valid    <= 1'b0;
            s1_x        <= '0;
            s1_idx      <= '0;
            out_valid   <= 1'b0;
            out_delta   <= '0;
            out_sign    <= 1'b0;
            out_outlier <= 1'b0;
            out_value   <= '0;
            out_index   <= '0;
            out_last    <= 1'b0;
        end else begin
            case (state)
                INIT: begin
                    init_addr <= init_addr + 1'b1;
                    if (init_addr == LAST_IDX) begin
                        state <= RUN;
                    end
                end
                RUN: ;
                default: state <= INIT;
            endcase

            if (accept) begin
                s1_valid <= 1'b1;
                s1_x     <= $signed(in_data);
                s1_idx   <= idx;
                idx      <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
            end else if (s2_move) begin
                s1_valid <= 1'b0;
            end

            if (s2_move) begin
                out_valid   <= 1'b1;
                out_delta   <= inlier ? q[DELTA_WIDTH-1:0] : '0;
                out_sign    <= s1_x[FULL_WIDTH-1];
                out_outlier <= ~inlier;
                out_value   <= inlier ? '0 : s1_x;
                out_index   <= s1_idx;
                out_last    <= (s1_idx == LAST_IDX);
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_cambricon_d_delta_encoder.sv
// Directed bench for cambricon_d_delta_encoder at FRAME_SIZE=16, SHIFT=4, DELTA_WIDTH=3.
module tb_cambricon_d_delta_encoder;

    localparam int N = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [2:0]  out_delta;
    logic        out_sign;
    logic        out_outlier;
    logic [15:0] out_value;
    logic [3:0]  out_index;
    logic        out_last;

    int compared   = 0;
    int mismatched = 0;

    logic [25:0] got;
    logic [25:0] exp;
    int          lat;

    always #5 clk = ~clk;

    assign got = {out_delta, out_sign, out_outlier, out_value, out_index, out_last};

    cambricon_d_delta_encoder #(
        .FRAME_SIZE  (16),
        .FULL_WIDTH  (16),
        .DELTA_WIDTH (3),
        .SHIFT       (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_delta   (out_delta),
        .out_sign    (out_sign),
        .out_outlier (out_outlier),
        .out_value   (out_value),
        .out_index   (out_index),
        .out_last    (out_last)
    );

    task automatic send_beat(input logic [15:0] x);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_data  = x;
        #1;
        while (!in_ready && n < 64) begin
            @(negedge clk);
            #1;
            n++;
        end
        compared++;
        if (!in_ready) begin
            mismatched++;
            $display("FAIL send_timeout: in_ready=%b required 1", in_ready);
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_out(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!out_valid && n < 64);
        compared++;
        if (!out_valid) begin
            mismatched++;
            $display("FAIL out_timeout: out_valid=%b required 1", out_valid);
        end
    endtask

    task automatic test_reset();
        int  n;
        logic seen;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        compared++;
        if ({out_valid, got, in_ready} !== '0) begin
            mismatched++;
            $display("FAIL reset_state: got %h required 0", {out_valid, got, in_ready});
        end
        rst  = 1'b0;
        n    = 0;
        seen = 1'b0;
        #1;
        while (!in_ready && n < 64) begin
            if (out_valid) seen = 1'b1;
            @(negedge clk);
            #1;
            n++;
        end
        compared++;
        if (n != 16) begin
            mismatched++;
            $display("FAIL init_cycles: got %0d required 16", n);
        end
        compared++;
        if (seen !== 1'b0) begin
            mismatched++;
            $display("FAIL init_out_valid: got %b required 0", seen);
        end
        compared++;
        if (in_ready !== 1'b1) begin
            mismatched++;
            $display("FAIL run_in_ready: got %b required 1", in_ready);
        end
    endtask

    // Two frames: inlier, outlier and negative-rounding cases, then re-encoded against updated refs.
    task automatic test_frames();
        for (int f = 0; f < 2; f++) begin
            for (int i = 0; i < N; i++) begin
                logic [15:0] x;
                x = (i == 0) ? 16'd32 : (i == 1) ? 16'hFF38 : (i == 2) ? 16'hFFFF : 16'd0;
                send_beat(x);
                wait_out(lat);
                compared++;
                if (lat != 1) begin
                    mismatched++;
                    $display("FAIL latency f%0d i%0d: got %0d required 1", f, i, lat);
                end
                if (f == 0) begin
                    case (i)
                        0:       exp = {3'b010, 1'b0, 1'b0, 16'h0000, 4'd0, 1'b0};
                        1:       exp = {3'b000, 1'b1, 1'b1, 16'hFF38, 4'd1, 1'b0};
                        2:       exp = {3'b111, 1'b1, 1'b0, 16'h0000, 4'd2, 1'b0};
                        default: exp = {3'b000, 1'b0, 1'b0, 16'h0000, 4'(i), i == N - 1};
                    endcase
                end else begin
                    case (i)
                        0:       exp = {3'b000, 1'b0, 1'b0, 16'h0000, 4'd0, 1'b0};
                        1:       exp = {3'b000, 1'b1, 1'b0, 16'h0000, 4'd1, 1'b0};
                        2:       exp = {3'b000, 1'b1, 1'b0, 16'h0000, 4'd2, 1'b0};
                        default: exp = {3'b000, 1'b0, 1'b0, 16'h0000, 4'(i), i == N - 1};
                    endcase
                end
                compared++;
                if (got !== exp) begin
                    mismatched++;
                    $display("FAIL beat f%0d i%0d: got %h required %h", f, i, got, exp);
                end
            end
        end
    endtask

    // Full-rate stream with a 5-cycle output stall when index 7 is presented.
    task automatic test_back_to_back();
        int k;
        int rx;
        k  = 0;
        rx = 0;
        fork
            begin
                int  g;
                logic acc;
                g = 0;
                while (k < N && g < 300) begin
                    in_valid = 1'b1;
                    in_data  = (k < 3) ? 16'd0 : 16'(16 * k);
                    #1;
                    acc = in_ready;
                    @(negedge clk);
                    g++;
                    if (acc) k++;
                end
                in_valid = 1'b0;
            end
            begin
                int          g;
                int          stall_left;
                logic        stalled;
                logic [25:0] snap;
                logic [25:0] e;
                g          = 0;
                stall_left = 0;
                stalled    = 1'b0;
                snap       = '0;
                while (rx < N && g < 300) begin
                    @(negedge clk);
                    g++;
                    if (out_valid) begin
                        if (!stalled && out_index == 4'd7) begin
                            stalled    = 1'b1;
                            stall_left = 5;
                            snap       = got;
                        end
                        if (stall_left > 0) begin
                            out_ready = 1'b0;
                            if (stall_left < 5) begin
                                compared++;
                                if (got !== snap) begin
                                    mismatched++;
                                    $display("FAIL stall_hold: got %h required %h", got, snap);
                                end
                            end
                            stall_left--;
                        end else begin
                            out_ready = 1'b1;
                            case (rx)
                                0:       e = {3'b110, 1'b0, 1'b0, 16'h0000, 4'd0, 1'b0};
                                1:       e = {3'b000, 1'b0, 1'b1, 16'h0000, 4'd1, 1'b0};
                                2:       e = {3'b001, 1'b0, 1'b0, 16'h0000, 4'd2, 1'b0};
                                3:       e = {3'b011, 1'b0, 1'b0, 16'h0000, 4'd3, 1'b0};
                                default: e = {3'b000, 1'b0, 1'b1, 16'(16 * rx), 4'(rx), rx == N - 1};
                            endcase
                            compared++;
                            if (got !== e) begin
                                mismatched++;
                                $display("FAIL stream_beat %0d: got %h required %h", rx, got, e);
                            end
                            rx++;
                        end
                    end else begin
                        out_ready = 1'b1;
                    end
                end
                out_ready = 1'b1;
            end
        join
        compared++;
        if (k != N || rx != N) begin
            mismatched++;
            $display("FAIL stream_count: sent %0d received %0d required %0d", k, rx, N);
        end
    endtask

    // Reset while beat 9 is offered: outputs clear, INIT reruns, refs are re-zeroed.
    task automatic test_reset_mid_frame();
        int   n;
        for (int i = 0; i < 9; i++) begin
            send_beat(16'd100);
        end
        in_valid = 1'b1;
        in_data  = 16'd100;
        rst      = 1'b1;
        @(negedge clk);
        compared++;
        if ({out_valid, got, in_ready} !== '0) begin
            mismatched++;
            $display("FAIL mid_reset_state: got %h required 0", {out_valid, got, in_ready});
        end
        in_valid = 1'b0;
        rst      = 1'b0;
        n        = 0;
        #1;
        while (!in_ready && n < 64) begin
            @(negedge clk);
            #1;
            n++;
        end
        compared++;
        if (n != 16) begin
            mismatched++;
            $display("FAIL mid_init_cycles: got %0d required 16", n);
        end
        send_beat(16'd32);
        wait_out(lat);
        exp = {3'b010, 1'b0, 1'b0, 16'h0000, 4'd0, 1'b0};
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("FAIL post_reset_beat: got %h required %h", got, exp);
        end
    endtask

    initial begin
        test_reset();
        test_frames();
        test_back_to_back();
        test_reset_mid_frame();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
